wm_panel_ctrl: RTL and testbench

//   Front-panel controller that drives the washing-machine controller's start/stop inputs.
//   It is the initiator side of that interface.
//   - Debounces the raw START/STOP buttons.
//   - Sequences start/stop against the machine's door_locked, drained and Finish_alarm

---
 rtl/wm_panel_ctrl.sv | 108 ++++++++++
 tb/tb_wm_panel_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wm_panel_ctrl.sv
// wm_panel_ctrl: front-panel button debounce and start/stop sequencer for the washing-machine controller
module wm_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCK_TIMEOUT    = 16,
    parameter int ALARM_CYCLES    = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       door_locked,
    input  logic       drained,
    input  logic       finish_alarm,
    output logic       start,
    output logic       stop,
    output logic       buzzer,
    output logic       led_run,
    output logic       led_done,
    output logic       led_fault,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        RUN      = 3'd2,
        STOPPING = 3'd3,
        DONE     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync1_q, sync2_q, db_q, db_d, dbp_q;
    logic [1:0][CNT_W-1:0]   dcnt_q, dcnt_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic                    start_evt, stop_evt;

    // bit 0 is START, bit 1 is STOP; stop beats start when both edges coincide
    assign stop_evt  = db_q[1] & ~dbp_q[1];
    assign start_evt = db_q[0] & ~dbp_q[0] & ~stop_evt;
    assign state_o   = state_q;

    // debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        db_d   = db_q;
        dcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1))
                    db_d[i] = sync2_q[i];
                else
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    // sequencing against the machine's responses
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_evt) state_d = REQ;
            REQ:      if (stop_evt) state_d = IDLE;
                      else if (door_locked) state_d = RUN;
                      else if (timer_q >= CNT_W'(LOCK_TIMEOUT - 1)) state_d = FAULT;
            RUN:      if (finish_alarm) state_d = DONE;
                      else if (stop_evt) state_d = STOPPING;
                      else if (!door_locked) state_d = FAULT;
            STOPPING: if (drained && !door_locked) state_d = IDLE;
            DONE:     if (stop_evt || timer_q >= CNT_W'(ALARM_CYCLES - 1)) state_d = IDLE;
            FAULT:    if (stop_evt) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        timer_d = (state_d != state_q) ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
    end

    // state, debounce and registered output decode of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            dbp_q     <= '0;
            dcnt_q    <= '0;
            timer_q   <= '0;
            start     <= 1'b0;
            stop      <= 1'b0;
            buzzer    <= 1'b0;
            led_run   <= 1'b0;
            led_done  <= 1'b0;
            led_fault <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= {btn_stop, btn_start};
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            dbp_q     <= db_q;
            dcnt_q    <= dcnt_d;
            timer_q   <= timer_d;
            start     <= state_d == REQ || state_d == RUN || state_d == STOPPING;
            stop      <= state_d == STOPPING;
            buzzer    <= state_d == DONE;
            led_run   <= state_d == REQ || state_d == RUN || state_d == STOPPING;
            led_done  <= state_d == DONE;
            led_fault <= state_d == FAULT;
        end
    end
endmodule

// File: tb/tb_wm_panel_ctrl.sv
// tb_wm_panel_ctrl: scoreboard bench for the front-panel controller
module tb_wm_panel_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_start = 1'b0, btn_stop = 1'b0;
    logic door_locked = 1'b0, drained = 1'b0, finish_alarm = 1'b0;
    logic start, stop, buzzer, led_run, led_done, led_fault;
    logic [2:0] state_o;

    typedef struct {
        logic [8:0] v;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 1'b0;
    logic [8:0] last;
    logic [8:0] cur;

    wm_panel_ctrl dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
        .door_locked(door_locked), .drained(drained), .finish_alarm(finish_alarm),
        .start(start), .stop(stop), .buzzer(buzzer), .led_run(led_run),
        .led_done(led_done), .led_fault(led_fault), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cur = {start, stop, buzzer, led_run, led_done, led_fault, state_o};

    // {start, stop, buzzer, led_run, led_done, led_fault, state}
    function automatic logic [8:0] ev(input int s);
        case (s)
            1:       return {6'b100100, 3'd1};
            2:       return {6'b100100, 3'd2};
            3:       return {6'b110100, 3'd3};
            4:       return {6'b001010, 3'd4};
            5:       return {6'b000001, 3'd5};
            default: return 9'd0;
        endcase
    endfunction

    task automatic expect_at(input int s, input int at);
        exp_t e;
        e.v  = ev(s);
        e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_run();
        int c;
        c = cyc;
        btn_start = 1'b1;
        expect_at(1, c + 7);
        tick(6);
        btn_start = 1'b0;
        tick(2);
        door_locked = 1'b1;
        expect_at(2, cyc + 1);
        tick(8);
    endtask

    // monitor: every change of the output vector must match the head of the queue
    always @(negedge clk) begin
        if (mon_en && cur !== last) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, cur);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (cur !== e.v) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%b want=%b", cyc, cur, e.v);
                end
                total++;
                if (cyc != e.at) begin
                    bad++;
                    $display("FAIL timing got_cycle=%0d want_cycle=%0d", cyc, e.at);
                end
            end
            last = cur;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c;
        int s;
        tick(2);
        rst = 1'b0;
        total++;
        if (cur !== 9'd0) begin
            bad++;
            $display("FAIL reset got=%b want=%b", cur, 9'd0);
        end
        last   = 9'd0;
        mon_en = 1'b1;
        tick(2);

        c = cyc;
        btn_start = 1'b1;
        expect_at(1, c + 7);
        tick(10);
        btn_start = 1'b0;
        door_locked = 1'b1;
        expect_at(2, cyc + 1);
        tick(2);
        finish_alarm = 1'b1;
        expect_at(4, cyc + 1);
        expect_at(0, cyc + 9);
        tick(1);
        finish_alarm = 1'b0;
        door_locked = 1'b0;
        tick(12);

        btn_start = 1'b1;
        tick(3);
        btn_start = 1'b0;
        tick(1);
        btn_start = 1'b1;
        tick(3);
        btn_start = 1'b0;
        tick(10);

        go_run();
        c = cyc;
        btn_stop = 1'b1;
        expect_at(3, c + 7);
        tick(8);
        btn_stop = 1'b0;
        tick(2);
        drained = 1'b1;
        tick(8);
        door_locked = 1'b0;
        expect_at(0, cyc + 1);
        tick(2);
        drained = 1'b0;
        tick(8);

        c = cyc;
        btn_start = 1'b1;
        expect_at(1, c + 7);
        expect_at(5, c + 23);
        tick(6);
        btn_start = 1'b0;
        tick(20);
        c = cyc;
        btn_stop = 1'b1;
        expect_at(0, c + 7);
        tick(8);
        btn_stop = 1'b0;
        tick(8);

        btn_start = 1'b1;
        btn_stop  = 1'b1;
        tick(6);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        tick(10);
        go_run();
        c = cyc;
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        expect_at(3, c + 7);
        tick(8);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        tick(2);
        drained = 1'b1;
        door_locked = 1'b0;
        expect_at(0, cyc + 1);
        tick(2);
        drained = 1'b0;
        tick(8);

        go_run();
        s = cyc;
        btn_stop = 1'b1;
        expect_at(4, s + 3);
        expect_at(0, s + 7);
        tick(2);
        finish_alarm = 1'b1;
        tick(1);
        finish_alarm = 1'b0;
        door_locked = 1'b0;
        tick(5);
        btn_stop = 1'b0;
        tick(10);

        go_run();
        s = cyc;
        btn_stop = 1'b1;
        expect_at(4, s + 7);
        expect_at(0, s + 15);
        tick(6);
        finish_alarm = 1'b1;
        tick(1);
        finish_alarm = 1'b0;
        door_locked = 1'b0;
        tick(2);
        btn_stop = 1'b0;
        tick(16);

        go_run();
        rst = 1'b1;
        expect_at(0, cyc + 1);
        tick(2);
        rst = 1'b0;
        door_locked = 1'b0;
        tick(4);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
